// File: rtl/alu_iter_pkg.sv
// Shared op-code encoding, FSM state encoding and LUI constants for alu_iter_exec.
// Op codes match the ALU control decoder output.
package alu_iter_pkg;
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_OR  = 4'b0010;
    localparam logic [3:0] ALU_SLL = 4'b0011;
    localparam logic [3:0] ALU_SRL = 4'b0100;
    localparam logic [3:0] ALU_LUI = 4'b0101;

    localparam int LUI_SHIFT = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;
endpackage

// File: rtl/alu_iter_shifter.sv
// One-bit-per-cycle shift register with shamt down-counter; shifted_o is the value after this cycle's shift.
// Latency: load then N enable cycles; last_o flags the cycle performing the final shift. No backpressure.
module alu_iter_shifter #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load_i,
    input  logic                   en_i,
    input  logic                   dir_left_i,
    input  logic [DATA_WIDTH-1:0]  data_i,
    input  logic [SHAMT_WIDTH-1:0] shamt_i,
    output logic [DATA_WIDTH-1:0]  shifted_o,
    output logic                   last_o
);
    logic [DATA_WIDTH-1:0]  sr_q;
    logic [SHAMT_WIDTH-1:0] cnt_q;
    logic                   left_q;

    assign shifted_o = left_q ? (sr_q << 1) : (sr_q >> 1);
    assign last_o    = (cnt_q == SHAMT_WIDTH'(1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr_q   <= '0;
            cnt_q  <= '0;
            left_q <= 1'b0;
        end else if (load_i) begin
            sr_q   <= data_i;
            cnt_q  <= shamt_i;
            left_q <= dir_left_i;
        end else if (en_i) begin
            sr_q   <= shifted_o;
            cnt_q  <= cnt_q - SHAMT_WIDTH'(1);
        end
    end
endmodule

// File: rtl/alu_iter_exec.sv
// Multicycle ALU with start/ready/done handshake; non-shift ops finish with done_o at accept+1, shifts at accept+N+1.
// start_i is ignored while busy (no queueing). ALU_ITER_FAST_SHIFT_EN makes shifts single-pass like other ops.
module alu_iter_exec
    import alu_iter_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    output logic                  ready_o,
    input  logic [3:0]            ALU_Operation_i,
    input  logic [DATA_WIDTH-1:0] A_i,
    input  logic [DATA_WIDTH-1:0] B_i,
    output logic [DATA_WIDTH-1:0] ALU_Result_o,
    output logic                  Zero_o,
    output logic                  done_o
);
    state_t                 state_q;
    logic                   ready_q;
    logic                   done_q;
    logic                   zero_q;
    logic [DATA_WIDTH-1:0]  result_q;

    logic [SHAMT_WIDTH-1:0] shamt;
    logic [31:0]            lui_word;
    logic [DATA_WIDTH-1:0]  lui_ext;
    logic [DATA_WIDTH-1:0]  imm_result;
    logic                   go_shift;
    logic [DATA_WIDTH-1:0]  shift_val;
    logic                   shift_last;
    logic                   accept;

    assign shamt    = B_i[SHAMT_WIDTH-1:0];
    assign lui_word = B_i[31:0] << LUI_SHIFT;
    assign lui_ext  = DATA_WIDTH'($signed(lui_word));
    assign accept   = (state_q == IDLE) && start_i;

    always_comb begin
        imm_result = '0;
        case (ALU_Operation_i)
            ALU_ADD: imm_result = A_i + B_i;
            ALU_SUB: imm_result = A_i - B_i;
            ALU_OR:  imm_result = A_i | B_i;
            ALU_LUI: imm_result = lui_ext;
`ifdef ALU_ITER_FAST_SHIFT_EN
            ALU_SLL: imm_result = A_i << shamt;
            ALU_SRL: imm_result = A_i >> shamt;
`else
            // Only reaches the result register when shamt is zero.
            ALU_SLL, ALU_SRL: imm_result = A_i;
`endif
            default: imm_result = '0;
        endcase
    end

`ifdef ALU_ITER_FAST_SHIFT_EN
    assign go_shift   = 1'b0;
    assign shift_val  = '0;
    assign shift_last = 1'b0;
`else
    assign go_shift = ((ALU_Operation_i == ALU_SLL) || (ALU_Operation_i == ALU_SRL))
                      && (shamt != '0);

    alu_iter_shifter #(
        .DATA_WIDTH  (DATA_WIDTH),
        .SHAMT_WIDTH (SHAMT_WIDTH)
    ) u_shifter (
        .clk        (clk),
        .reset      (reset),
        .load_i     (accept && go_shift),
        .en_i       (state_q == SHIFT),
        .dir_left_i (ALU_Operation_i == ALU_SLL),
        .data_i     (A_i),
        .shamt_i    (shamt),
        .shifted_o  (shift_val),
        .last_o     (shift_last)
    );
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        ready_q <= 1'b0;
                        if (go_shift) begin
                            state_q <= SHIFT;
                        end else begin
                            state_q  <= DONE;
                            done_q   <= 1'b1;
                            result_q <= imm_result;
                            zero_q   <= (imm_result == '0);
                        end
                    end
                end
                SHIFT: begin
                    if (shift_last) begin
                        state_q  <= DONE;
                        done_q   <= 1'b1;
                        result_q <= shift_val;
                        zero_q   <= (shift_val == '0);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign ready_o      = ready_q;
    assign done_o       = done_q;
    assign ALU_Result_o = result_q;
    assign Zero_o       = zero_q;
endmodule

// File: tb/tb_alu_iter_exec.sv
// Self-checking bench for alu_iter_exec: directed vector table, handshake corner sequences, random ops vs. reference model.
module tb_alu_iter_exec;
`ifdef ALU_ITER_FAST_SHIFT_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start_i = 1'b0;
    logic        ready_o;
    logic [3:0]  op_i = 4'h0;
    logic [31:0] a_i = '0;
    logic [31:0] b_i = '0;
    logic [31:0] res_o;
    logic        zero_o;
    logic        done_o;

    int checks = 0;
    int errors = 0;
    logic [31:0] prev_res = '0;

    alu_iter_exec dut (
        .clk             (clk),
        .reset           (reset),
        .start_i         (start_i),
        .ready_o         (ready_o),
        .ALU_Operation_i (op_i),
        .A_i             (a_i),
        .B_i             (b_i),
        .ALU_Result_o    (res_o),
        .Zero_o          (zero_o),
        .done_o          (done_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference behaviour from the op definitions.
    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int sh;
        logic [31:0] r;
        sh = int'(b[4:0]);
        case (op)
            4'd0:    r = a + b;
            4'd1:    r = a - b;
            4'd2:    r = a | b;
            4'd3:    r = a << sh;
            4'd4:    r = a >> sh;
            4'd5:    r = {b[19:0], 12'h000};
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    function automatic int ref_lat(input logic [3:0] op, input logic [31:0] b);
        if ((op == 4'd3 || op == 4'd4) && !FAST)
            return int'(b[4:0]) + 1;
        return 1;
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (!ready_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!ready_o) chk("ready_timeout", {31'b0, ready_o}, 32'h1);
    endtask

    // Issue one op from a negedge, then check latency, hold, result and return to ready.
    task automatic do_op(input string nm, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        int k = 0;
        bit seen = 1'b0;
        wait_ready();
        start_i = 1'b1;
        op_i = op;
        a_i = a;
        b_i = b;
        @(posedge clk);
        while (!seen && k < 100) begin
            @(negedge clk);
            start_i = 1'b0;
            k++;
            if (done_o) begin
                seen = 1'b1;
                chk({nm, "_rdy_during_done"}, {31'b0, ready_o}, 32'h0);
            end else if (k <= exp_lat) begin
                chk({nm, "_hold"}, res_o, prev_res);
                chk({nm, "_busy"}, {31'b0, ready_o}, 32'h0);
            end
        end
        chk({nm, "_lat"}, k, exp_lat);
        chk({nm, "_res"}, res_o, exp_res);
        chk({nm, "_zero"}, {31'b0, zero_o}, {31'b0, exp_res == 32'h0});
        @(negedge clk);
        chk({nm, "_done_pulse"}, {31'b0, done_o}, 32'h0);
        chk({nm, "_ready_back"}, {31'b0, ready_o}, 32'h1);
        chk({nm, "_res_held"}, res_o, exp_res);
        prev_res = exp_res;
    endtask

    initial begin
        int k;
        bit seen;
        logic [3:0]  rop;
        logic [31:0] ra, rb;

        tbl[0] = '{4'h0, 32'h0000_0005, 32'hFFFF_FFFB, 32'h0000_0000, 1};
        tbl[1] = '{4'h1, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1};
        tbl[2] = '{4'h2, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1};
        tbl[3] = '{4'h5, 32'h1111_1111, 32'h0001_2345, 32'h1234_5000, 1};
        tbl[4] = '{4'h3, 32'h0000_0001, 32'hFFFF_FFE4, 32'h0000_0010, FAST ? 1 : 5};
        tbl[5] = '{4'h4, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001, FAST ? 1 : 32};
        tbl[6] = '{4'h3, 32'hDEAD_BEEF, 32'h0000_0000, 32'hDEAD_BEEF, 1};
        tbl[7] = '{4'hA, 32'h0000_0123, 32'h0000_0456, 32'h0000_0000, 1};
        tbl[8] = '{4'h5, 32'h0, 32'h0008_0000, 32'h8000_0000, 1};

        repeat (3) @(negedge clk);
        chk("rst_ready", {31'b0, ready_o}, 32'h1);
        chk("rst_done", {31'b0, done_o}, 32'h0);
        chk("rst_res", res_o, 32'h0);
        chk("rst_zero", {31'b0, zero_o}, 32'h1);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++)
            do_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].lat);

        // start_i held high through a 10-bit SRL; second request must wait for ready.
        wait_ready();
        start_i = 1'b1;
        op_i = 4'h4;
        a_i = 32'h8000_0000;
        b_i = 32'h0000_000A;
        @(posedge clk);
        #1;
        op_i = 4'h0;
        a_i = 32'h1;
        b_i = 32'h2;
        k = 0;
        seen = 1'b0;
        while (!seen && k < 100) begin
            @(negedge clk);
            k++;
            if (done_o) seen = 1'b1;
            else chk("held_hold", res_o, prev_res);
        end
        chk("held_lat", k, FAST ? 1 : 11);
        chk("held_res", res_o, 32'h0020_0000);
        @(negedge clk);
        chk("held_ready", {31'b0, ready_o}, 32'h1);
        chk("held_no_done", {31'b0, done_o}, 32'h0);
        @(negedge clk);
        start_i = 1'b0;
        chk("held2_done", {31'b0, done_o}, 32'h1);
        chk("held2_res", res_o, 32'h3);
        @(negedge clk);
        prev_res = 32'h3;

        // Reset in the third cycle of a shamt=20 SLL aborts without a done pulse.
        wait_ready();
        start_i = 1'b1;
        op_i = 4'h3;
        a_i = 32'h1;
        b_i = 32'd20;
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort_ready", {31'b0, ready_o}, 32'h1);
        chk("abort_done", {31'b0, done_o}, 32'h0);
        chk("abort_res", res_o, 32'h0);
        chk("abort_zero", {31'b0, zero_o}, 32'h1);
        @(negedge clk);
        reset = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (done_o) seen = 1'b1;
        end
        chk("abort_no_done", {31'b0, seen}, 32'h0);
        chk("abort_idle_ready", {31'b0, ready_o}, 32'h1);
        prev_res = 32'h0;

        for (int i = 0; i < 40; i++) begin
            rop = (i % 3 == 0) ? 4'(3 + $urandom_range(0, 1)) : 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = (i % 7 == 0) ? 32'h0 : $urandom;
            do_op($sformatf("rnd%0d", i), rop, ra, rb, ref_alu(rop, ra, rb), ref_lat(rop, rb));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    always @(negedge clk) begin
        if (reset && done_o && ready_o) begin
            errors++;
            $display("FAIL done_ready_overlap: got done=1 ready=1 expected not both");
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
